// File: rtl/ifetch_queue_if.sv
// Pipelined Wishbone bundle for the instruction fetch port.
// The master drives the request side; the slave returns data, ack and stall.
interface if_wb;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat_w;
    logic [31:0] dat_r;
    logic        ack;
    logic        stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, stall
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch/prefetch queue: pipelined Wishbone master that buffers
// returned words with their addresses and discards responses made stale by a redirect.
module ifetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    if_wb.master        ins_bus,
    input  logic        pc_set,
    input  logic [31:0] pc_new,
    input  logic        halt,
    input  logic        ins_pop,
    output logic        ins_valid,
    output logic [31:0] ins_word,
    output logic [31:0] ins_pc
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    typedef logic [CW-1:0] cnt_t;
    typedef logic [AW-1:0] ptr_t;

    logic        stb_q, stb_d;
    logic [31:0] fetch_adr_q, fetch_adr_d;
    logic [31:0] resp_adr_q, resp_adr_d;
    cnt_t        occ_q, occ_d;
    cnt_t        inflight_q, inflight_d;
    cnt_t        stale_q, stale_d;
    ptr_t        head_q, head_d;
    ptr_t        tail_q, tail_d;
    logic [31:0] word_q [DEPTH];
    logic [31:0] pc_q   [DEPTH];

    logic        accept;
    logic        ack_v;
    logic        drop;
    logic        push;
    logic        pop;
    logic [CW:0] load;

    assign accept = stb_q && !ins_bus.stall;
    assign ack_v  = ins_bus.ack && (inflight_q != '0);
    assign drop   = ack_v && (stale_q != '0);
    assign push   = ack_v && !drop && !pc_set;
    assign pop    = ins_valid && ins_pop && !pc_set;

    assign ins_bus.cyc   = stb_q || (inflight_q != '0);
    assign ins_bus.stb   = stb_q;
    assign ins_bus.we    = 1'b0;
    assign ins_bus.adr   = fetch_adr_q;
    assign ins_bus.sel   = 4'hf;
    assign ins_bus.dat_w = 32'h0;

    assign ins_valid = (occ_q != '0);
    assign ins_word  = word_q[head_q];
    assign ins_pc    = pc_q[head_q];

    always_comb begin
        inflight_d  = inflight_q + cnt_t'(accept) - cnt_t'(ack_v);
        occ_d       = occ_q + cnt_t'(push) - cnt_t'(pop);
        stale_d     = stale_q - cnt_t'(drop);
        head_d      = head_q + ptr_t'(pop);
        tail_d      = tail_q + ptr_t'(push);
        fetch_adr_d = accept ? fetch_adr_q + 32'd4 : fetch_adr_q;
        resp_adr_d  = push ? resp_adr_q + 32'd4 : resp_adr_q;
        if (pc_set) begin
            // Everything still outstanding, including this cycle's accept, is stale.
            occ_d       = '0;
            stale_d     = inflight_d;
            head_d      = '0;
            tail_d      = '0;
            fetch_adr_d = pc_new;
            resp_adr_d  = pc_new;
        end
        load  = {1'b0, occ_d} + {1'b0, inflight_d};
        stb_d = !halt && !pc_set && (load < DEPTH_C);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stb_q       <= 1'b0;
            fetch_adr_q <= RESET_PC;
            resp_adr_q  <= RESET_PC;
            occ_q       <= '0;
            inflight_q  <= '0;
            stale_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
        end else begin
            stb_q       <= stb_d;
            fetch_adr_q <= fetch_adr_d;
            resp_adr_q  <= resp_adr_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            stale_q     <= stale_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (push) begin
            word_q[tail_q] <= ins_bus.dat_r;
            pc_q[tail_q]   <= resp_adr_q;
        end
    end
endmodule
